// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO with occupancy, almost-full warning
// and a sticky overflow flag that records producer writes dropped while full.
module result_fifo #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_req,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   output logic                     almost_full,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [LW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;

   logic pop;
   logic push;
   logic drop;

   // Status flags decode the registered level only, so they never glitch.
   assign full        = (level_q == LW'(DEPTH));
   assign almost_full = (level_q >= LW'(AF_LEVEL));
   assign out_valid   = (level_q != '0);
   assign out_data    = mem_q[rp_q];
   assign level       = level_q;
   assign overflow    = overflow_q;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      pop        = out_valid && out_ready;
      push       = wr_req && (!full || pop);
      drop       = wr_req && full && !pop;
      wp_d       = wp_q;
      rp_d       = rp_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);

      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);

      // A drop in the same cycle as a clear must still be recorded.
      if (drop)         overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; stale words are
   // unreachable because out_valid follows the level counter.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wp_q] <= wr_data;
   end

endmodule

// File: tb/tb_result_fifo.sv
// Table-driven bench for result_fifo: each vector drives one cycle and lists
// the expected post-edge status; popped data is checked against a scoreboard.
module tb_result_fifo;

   localparam int WIDTH    = 16;
   localparam int DEPTH    = 8;
   localparam int AF_LEVEL = 6;

   logic              clk;
   logic              rst;
   logic              wr_req;
   logic [WIDTH-1:0]  wr_data;
   logic              full;
   logic              almost_full;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [3:0]        level;
   logic              overflow;
   logic              clr_ovf;

   result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wr_req),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (almost_full),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .level       (level),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [15:0] d;
      logic        rdy;
      logic        clr;
      logic [3:0]  e_lvl;
      logic        e_vld;
      logic        e_full;
      logic        e_af;
      logic        e_ovf;
   } vec_t;

   vec_t        tv[$];
   logic [15:0] sb[$];
   int          n_vec;
   int          n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic [15:0] d,
                               input logic rdy, input logic c, input int lvl, input logic ovf);
      vec_t v;
      v.rst    = r;
      v.wr     = w;
      v.d      = d;
      v.rdy    = rdy;
      v.clr    = c;
      v.e_lvl  = 4'(lvl);
      v.e_vld  = (lvl != 0);
      v.e_full = (lvl == DEPTH);
      v.e_af   = (lvl >= AF_LEVEL);
      v.e_ovf  = ovf;
      return v;
   endfunction

   // Drive one cycle, consult the scoreboard for the consumer side, then
   // compare the status outputs one time unit after the edge.
   task automatic apply(input vec_t v);
      logic pop_m;
      logic push_m;
      rst       = v.rst;
      wr_req    = v.wr;
      wr_data   = v.d;
      out_ready = v.rdy;
      clr_ovf   = v.clr;
      #1;
      pop_m  = !v.rst && v.rdy && (sb.size() != 0);
      push_m = !v.rst && v.wr && ((sb.size() != DEPTH) || pop_m);
      if (v.rst) begin
         sb.delete();
      end else begin
         if (pop_m) check("pop_data", 32'(out_data), 32'(sb.pop_front()));
         if (push_m) sb.push_back(v.d);
      end
      @(posedge clk);
      #1;
      check("level",       32'(level),       32'(v.e_lvl));
      check("out_valid",   32'(out_valid),   32'(v.e_vld));
      check("full",        32'(full),        32'(v.e_full));
      check("almost_full", 32'(almost_full), 32'(v.e_af));
      check("overflow",    32'(overflow),    32'(v.e_ovf));
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      wr_req    = 1'b0;
      wr_data   = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0));

      // Three writes, hold, then drain in order.
      tv.push_back(mk(0, 1, 16'h0011, 0, 0, 1, 0));
      tv.push_back(mk(0, 1, 16'h0022, 0, 0, 2, 0));
      tv.push_back(mk(0, 1, 16'h0033, 0, 0, 3, 0));
      tv.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 2, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0));

      // Fill to full, drop a ninth write, clear, then push+pop while full.
      for (int i = 0; i < DEPTH; i++)
         tv.push_back(mk(0, 1, 16'h0100 + 16'(i), 0, 0, i + 1, 0));
      tv.push_back(mk(0, 1, 16'h0BAD, 0, 0, 8, 1));
      tv.push_back(mk(0, 0, 16'h0000, 0, 1, 8, 0));
      tv.push_back(mk(0, 1, 16'h0200, 1, 0, 8, 0));
      for (int i = DEPTH - 1; i >= 0; i--)
         tv.push_back(mk(0, 0, 16'h0000, 1, 0, i, 0));

      // Sticky overflow: hold, clear, and clear coinciding with a drop.
      for (int i = 0; i < DEPTH; i++)
         tv.push_back(mk(0, 1, 16'h0300 + 16'(i), 0, 0, i + 1, 0));
      tv.push_back(mk(0, 1, 16'hDEAD, 0, 0, 8, 1));
      tv.push_back(mk(0, 0, 16'h0000, 0, 0, 8, 1));
      tv.push_back(mk(0, 0, 16'h0000, 0, 1, 8, 0));
      tv.push_back(mk(0, 1, 16'hDEAE, 0, 0, 8, 1));
      tv.push_back(mk(0, 1, 16'hDEAF, 0, 1, 8, 1));
      tv.push_back(mk(0, 0, 16'h0000, 0, 1, 8, 0));
      for (int i = DEPTH - 1; i >= 0; i--)
         tv.push_back(mk(0, 0, 16'h0000, 1, 0, i, 0));

      // Streaming: 20 words through at level 1, wrapping the pointers.
      tv.push_back(mk(0, 1, 16'h0400, 1, 0, 1, 0));
      for (int i = 1; i < 20; i++)
         tv.push_back(mk(0, 1, 16'h0400 + 16'(i), 1, 0, 1, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0));

      // Reset mid-fill with a write pending; the write must be ignored.
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(0, 1, 16'h0500 + 16'(i), 0, 0, i + 1, 0));
      tv.push_back(mk(1, 1, 16'h0666, 0, 0, 0, 0));
      tv.push_back(mk(0, 1, 16'h0777, 0, 0, 1, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0));

      // Reset while full with overflow set.
      for (int i = 0; i < DEPTH; i++)
         tv.push_back(mk(0, 1, 16'h0800 + 16'(i), 0, 0, i + 1, 0));
      tv.push_back(mk(0, 1, 16'h0BAD, 0, 0, 8, 1));
      tv.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 0));
      tv.push_back(mk(0, 1, 16'h0999, 1, 0, 1, 0));
      tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0));

      foreach (tv[i]) apply(tv[i]);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
